// File: rtl/gmux_ctrl_pkg.sv
// Shared types and helpers for the PP3 GMUX select sequencer.
// Optional sticky request-error flag is built when GMUX_CTRL_ERR_EN is defined.
package gmux_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ACK    = 3'd1;
  localparam state_t S_GATE   = 3'd2;
  localparam state_t S_SWITCH = 3'd3;
  localparam state_t S_UNGATE = 3'd4;
  localparam state_t S_HOLD   = 3'd5;

  localparam logic SRC_IP = 1'b0;
  localparam logic SRC_IC = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gmux_ctrl_timer.sv
// Loadable down-counter shared by all timed states of the GMUX sequencer.
// Stops at zero; expire flags the last cycle of a timed state.
module gmux_ctrl_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/gmux_switch_ctrl.sv
// Glitch-safe IS0 sequencer for one PP3 GMUX, clocked by the free-running fabric clock.
// Define GMUX_CTRL_ERR_EN to add the sticky ERR flag and its ERR_CLR input.
module gmux_switch_ctrl
  import gmux_ctrl_pkg::*;
#(
  parameter logic RESET_SRC   = 1'b0,
  parameter int   GATE_CYC    = 4,
  parameter int   SETTLE_CYC  = 2,
  parameter int   HOLDOFF_CYC = 3
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic REQ_VALID,
  input  logic REQ_SRC,
  output logic REQ_READY,
  output logic DONE,
  output logic BUSY,
  output logic IS0,
  output logic CUR_SRC,
  output logic CLK_EN
`ifdef GMUX_CTRL_ERR_EN
  ,
  input  logic ERR_CLR,
  output logic ERR
`endif
);

  localparam int CW = $clog2(max3(GATE_CYC, SETTLE_CYC, HOLDOFF_CYC) + 1);

  state_t  state_q, state_d;
  logic    is0_q, is0_d;
  logic    cur_src_q, cur_src_d;
  logic    tgt_q, tgt_d;
  logic    clk_en_q, clk_en_d;
  logic    ld;
  logic [CW-1:0] ld_val;
  logic [CW-1:0] tmr_val;
  logic    tmr_exp;
  logic    adv;
  logic    accept;

  gmux_ctrl_timer #(
    .W (CW)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (ld),
    .load_val (ld_val),
    .value    (tmr_val),
    .expire   (tmr_exp)
  );

  assign adv    = tmr_exp && (tmr_val != '0);
  assign accept = REQ_VALID && (state_q == S_IDLE);

  always_comb begin
    state_d   = state_q;
    is0_d     = is0_q;
    cur_src_d = cur_src_q;
    tgt_d     = tgt_q;
    clk_en_d  = clk_en_q;
    ld        = 1'b0;
    ld_val    = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tgt_d = REQ_SRC;
          if (REQ_SRC == cur_src_q) begin
            state_d = S_ACK;
          end else begin
            state_d  = S_GATE;
            clk_en_d = 1'b0;
            ld       = 1'b1;
            ld_val   = CW'(GATE_CYC);
          end
        end
      end
      S_GATE: begin
        if (adv) begin
          state_d = S_SWITCH;
          is0_d   = tgt_q;
          ld      = 1'b1;
          ld_val  = CW'(SETTLE_CYC);
        end
      end
      S_SWITCH: begin
        if (adv) begin
          state_d   = S_UNGATE;
          clk_en_d  = 1'b1;
          cur_src_d = tgt_q;
        end
      end
      S_ACK, S_UNGATE: begin
        // Zero holdoff returns straight to IDLE
        if (HOLDOFF_CYC == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
          ld      = 1'b1;
          ld_val  = CW'(HOLDOFF_CYC);
        end
      end
      S_HOLD: begin
        if (adv) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        clk_en_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      is0_q     <= RESET_SRC;
      cur_src_q <= RESET_SRC;
      tgt_q     <= RESET_SRC;
      clk_en_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      is0_q     <= is0_d;
      cur_src_q <= cur_src_d;
      tgt_q     <= tgt_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_UNGATE) || (state_q == S_ACK);
  assign IS0       = is0_q;
  assign CUR_SRC   = cur_src_q;
  assign CLK_EN    = clk_en_q;

`ifdef GMUX_CTRL_ERR_EN
  logic err_q, err_d;

  // Set dominates a same-cycle clear
  always_comb begin
    err_d = err_q;
    if (ERR_CLR) begin
      err_d = 1'b0;
    end
    if (REQ_VALID && BUSY) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`endif

endmodule

// File: tb/tb_gmux_switch_ctrl.sv
// Directed bench for gmux_switch_ctrl (GATE=4, SETTLE=2, HOLDOFF=3, RESET_SRC=0).
// Also covers the ERR flag when built with GMUX_CTRL_ERR_EN.
module tb_gmux_switch_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  logic REQ_VALID;
  logic REQ_SRC;
  logic REQ_READY;
  logic DONE;
  logic BUSY;
  logic IS0;
  logic CUR_SRC;
  logic CLK_EN;
`ifdef GMUX_CTRL_ERR_EN
  logic ERR_CLR;
  logic ERR;
`endif

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  logic prev_is0 = 1'b0;

  gmux_switch_ctrl #(
    .RESET_SRC   (1'b0),
    .GATE_CYC    (4),
    .SETTLE_CYC  (2),
    .HOLDOFF_CYC (3)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_SRC   (REQ_SRC),
    .REQ_READY (REQ_READY),
    .DONE      (DONE),
    .BUSY      (BUSY),
    .IS0       (IS0),
    .CUR_SRC   (CUR_SRC),
    .CLK_EN    (CLK_EN)
`ifdef GMUX_CTRL_ERR_EN
    ,
    .ERR_CLR   (ERR_CLR),
    .ERR       (ERR)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // An IS0 change must never coincide with an enabled downstream clock
  always @(negedge CLK) begin
    if (mon_en) begin
      chk("glitch", {31'd0, CLK_EN && (IS0 !== prev_is0)}, 32'd0);
    end
    prev_is0 = IS0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    int nacc;
    bit acc;
    bit seen;
    RST_N     = 1'b0;
    REQ_VALID = 1'b0;
    REQ_SRC   = 1'b0;
`ifdef GMUX_CTRL_ERR_EN
    ERR_CLR   = 1'b0;
`endif
    step();
    step();
    RST_N = 1'b1;

    chk("rst_is0",   IS0,       0);
    chk("rst_clken", CLK_EN,    1);
    chk("rst_ready", REQ_READY, 1);
    chk("rst_busy",  BUSY,      0);
    chk("rst_done",  DONE,      0);
    chk("rst_cur",   CUR_SRC,   0);
`ifdef GMUX_CTRL_ERR_EN
    chk("rst_err",   ERR,       0);
`endif

    // Switch to IC; stray request at t2 must be ignored
    REQ_SRC   = 1'b1;
    REQ_VALID = 1'b1;
    for (int t = 1; t <= 11; t++) begin
      step();
      chk("sw_clken", CLK_EN,    (t < 1 || t > 6) ? 1 : 0);
      chk("sw_is0",   IS0,       (t >= 5) ? 1 : 0);
      chk("sw_done",  DONE,      (t == 7) ? 1 : 0);
      chk("sw_ready", REQ_READY, (t >= 11) ? 1 : 0);
      chk("sw_cur",   CUR_SRC,   (t >= 7) ? 1 : 0);
      REQ_VALID = (t == 2);
      REQ_SRC   = 1'b0;
    end
    step();
    chk("sw_noqueue", BUSY, 0);
    chk("sw_is0_end", IS0,  1);
`ifdef GMUX_CTRL_ERR_EN
    chk("err_set", ERR, 1);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("err_clr", ERR, 0);
`endif

    // Same-source request: ACK path
    REQ_SRC   = 1'b1;
    REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
    chk("ack_done",  DONE,   1);
    chk("ack_clken", CLK_EN, 1);
    chk("ack_is0",   IS0,    1);
    chk("ack_busy",  BUSY,   1);
    for (int t = 2; t <= 5; t++) begin
      step();
      chk("ack_ready", REQ_READY, (t == 5) ? 1 : 0);
      chk("ack_done2", DONE, 0);
    end

    // Back-to-back with alternating source
    mon_en    = 1'b1;
    REQ_SRC   = 1'b0;
    REQ_VALID = 1'b1;
    last = -1;
    nacc = 0;
    for (int c = 0; c < 60 && nacc < 4; c++) begin
      acc = REQ_READY && REQ_VALID;
      if (acc) begin
        if (last >= 0) chk("b2b_gap", c - last, 11);
        last = c;
        nacc++;
      end
      step();
      if (acc) begin
        REQ_SRC = ~REQ_SRC;
        if (nacc == 4) REQ_VALID = 1'b0;
      end
    end
    chk("b2b_count", nacc, 4);
    for (int w = 0; w < 20 && !REQ_READY; w++) step();
    chk("b2b_idle", REQ_READY, 1);
    chk("b2b_cur",  CUR_SRC,   1);
    chk("b2b_is0",  IS0,       1);
    mon_en = 1'b0;

    // Reset in the middle of a switch to IP
    REQ_SRC   = 1'b0;
    REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
    step();
    step();
    chk("ab_pre_clken", CLK_EN, 0);
    RST_N = 1'b0;
    step();
    chk("ab_is0",   IS0,       0);
    chk("ab_clken", CLK_EN,    1);
    chk("ab_done",  DONE,      0);
    chk("ab_ready", REQ_READY, 1);
    chk("ab_busy",  BUSY,      0);
    chk("ab_cur",   CUR_SRC,   0);
    RST_N = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (DONE || BUSY) seen = 1'b1;
    end
    chk("ab_quiet", seen, 0);

    // Same-source request for IP from reset state
    REQ_SRC   = 1'b0;
    REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
    chk("ip_done",  DONE,      1);
    chk("ip_clken", CLK_EN,    1);
    chk("ip_is0",   IS0,       0);
    chk("ip_ready", REQ_READY, 0);
    step();
    chk("ip_done2", DONE,      0);
    chk("ip_clk2",  CLK_EN,    1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
